// File: rtl/board_setup_ctrl.sv
// Game-start sequencer: fill 32 covered pieces, LFSR Fisher-Yates shuffle, write all squares.
// Setup takes 65 cycles minimum; game-logic writes pass through only in IDLE and are dropped while busy.
module board_setup_ctrl #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_RETRY = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       start,
    input  logic [4:0] gl_addr,
    input  logic [4:0] gl_piece,
    input  logic       gl_we,
    output logic [4:0] board_addr,
    output logic [4:0] board_piece,
    output logic       board_we,
    output logic       busy,
    output logic       game_hold,
    output logic       done
);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_SHUFFLE, S_WRITE, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [15:0]     lfsr;
    logic [4:0]      i, k;
    logic [RW-1:0]   retry;
    logic [4:0]      shadow [32];

    logic [4:0]      r, mask, d, j;
    logic            accept, fallback, do_swap;

    function automatic logic [4:0] canon(input logic [4:0] idx);
        logic [2:0] t;
        case (idx[3:0])
            4'd0:        t = 3'b111;
            4'd1, 4'd2:  t = 3'b110;
            4'd3, 4'd4:  t = 3'b101;
            4'd5, 4'd6:  t = 3'b100;
            4'd7, 4'd8:  t = 3'b011;
            4'd9, 4'd10: t = 3'b010;
            default:     t = 3'b001;
        endcase
        return {idx[4], t, 1'b0};
    endfunction

    // Draw: mask down to the smallest all-ones range covering i, reject out-of-range values.
    always_comb begin
        r = lfsr[4:0];
        if (i[4])      mask = 5'd31;
        else if (i[3]) mask = 5'd15;
        else if (i[2]) mask = 5'd7;
        else if (i[1]) mask = 5'd3;
        else           mask = 5'd1;
        d        = r & mask;
        accept   = (d <= i);
        fallback = (retry == RETRY_MAX);
        do_swap  = accept || fallback;
        j        = accept ? d : (r & (mask >> 1));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        board_addr  = 5'd0;
        board_piece = 5'd0;
        board_we    = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                board_addr  = gl_addr;
                board_piece = gl_piece;
                board_we    = gl_we;
                if (start) state_nxt = S_FILL;
            end
            S_FILL:    state_nxt = S_SHUFFLE;
            S_SHUFFLE: if (do_swap && i == 5'd1) state_nxt = S_WRITE;
            S_WRITE: begin
                board_we    = 1'b1;
                board_addr  = k;
                board_piece = shadow[k];
                if (k == 5'd31) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign game_hold = busy;

    // LFSR free-runs in every state so the moment of start picks the shuffle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lfsr  <= LFSR_SEED;
            i     <= 5'd0;
            k     <= 5'd0;
            retry <= '0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            case (state)
                S_FILL: begin
                    i     <= 5'd31;
                    retry <= '0;
                end
                S_SHUFFLE: begin
                    if (do_swap) begin
                        i     <= i - 5'd1;
                        retry <= '0;
                        if (i == 5'd1) k <= 5'd0;
                    end else begin
                        retry <= retry + 1'b1;
                    end
                end
                S_WRITE: k <= k + 5'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (state == S_FILL) begin
            for (int n = 0; n < 32; n++) shadow[n] <= canon(5'(n));
        end else if (state == S_SHUFFLE && do_swap) begin
            shadow[i] <= shadow[j];
            shadow[j] <= shadow[i];
        end
    end
endmodule

// File: tb/tb_board_setup_ctrl.sv
// Scoreboard bench: unit 0 has MAX_RETRY=0, unit 1 the default; both share all inputs.
module tb_board_setup_ctrl;
    logic       CLK = 1'b0;
    logic       RESET;
    logic       start;
    logic [4:0] gl_addr, gl_piece;
    logic       gl_we;

    logic [1:0][4:0] b_addr, b_piece;
    logic [1:0]      b_we, busy, hold, done;

    board_setup_ctrl #(.LFSR_SEED(16'hACE1), .MAX_RETRY(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .start(start),
        .gl_addr(gl_addr), .gl_piece(gl_piece), .gl_we(gl_we),
        .board_addr(b_addr[0]), .board_piece(b_piece[0]), .board_we(b_we[0]),
        .busy(busy[0]), .game_hold(hold[0]), .done(done[0]));

    board_setup_ctrl #(.LFSR_SEED(16'hACE1), .MAX_RETRY(15)) dut1 (
        .CLK(CLK), .RESET(RESET), .start(start),
        .gl_addr(gl_addr), .gl_piece(gl_piece), .gl_we(gl_we),
        .board_addr(b_addr[1]), .board_piece(b_piece[1]), .board_we(b_we[1]),
        .busy(busy[1]), .game_hold(hold[1]), .done(done[1]));

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (event not expected / not seen)", name);
    endtask

    function automatic logic [15:0] adv(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    logic [15:0] m_lfsr;
    int          cyc = 0;
    always @(posedge CLK or posedge RESET) begin
        if (RESET) m_lfsr <= 16'hACE1;
        else       m_lfsr <= adv(m_lfsr);
    end
    always @(posedge CLK) cyc <= cyc + 1;

    logic [9:0] expq    [2][$];
    int         expdone [2][$];
    int         wcnt [2];
    int         dcnt [2];
    int         hist [32];

    // Reference shuffle: canonical set, then one draw per cycle from the LFSR phase l0.
    task automatic push_setup(input int u, input logic [15:0] l0);
        logic [4:0]  a [32];
        logic [4:0]  tmp;
        logic [15:0] l;
        int ii, retry, mask, rr, d, j, ncyc, off, ty;
        int mr = (u == 0) ? 0 : 15;
        for (int n = 0; n < 32; n++) begin
            off = n % 16;
            ty  = (off == 0) ? 7 : (off <= 10) ? 6 - (off - 1) / 2 : 1;
            a[n] = {n[4], ty[2:0], 1'b0};
        end
        l = l0; ii = 31; retry = 0; ncyc = 0;
        while (ii >= 1) begin
            ncyc++;
            rr = int'(l[4:0]);
            mask = 1;
            while (mask < ii) mask = mask * 2 + 1;
            d = rr & mask;
            if (d <= ii)           j = d;
            else if (retry == mr)  j = rr & (mask >> 1);
            else                   j = -1;
            if (j >= 0) begin
                tmp = a[ii]; a[ii] = a[j]; a[j] = tmp;
                ii--; retry = 0;
            end else begin
                retry++;
            end
            l = adv(l);
        end
        for (int n = 0; n < 32; n++) expq[u].push_back({n[4:0], a[n]});
        expdone[u].push_back(cyc + 34 + ncyc);
    endtask

    task automatic flush();
        for (int u = 0; u < 2; u++) begin
            expq[u].delete();
            expdone[u].delete();
            wcnt[u] = 0;
        end
        for (int v = 0; v < 32; v++) hist[v] = 0;
    endtask

    // Monitor: every busy-time board write is popped against the scoreboard.
    always @(negedge CLK) begin
        if (!RESET) begin
            for (int u = 0; u < 2; u++) begin
                if (busy[u] && b_we[u]) begin
                    wcnt[u]++;
                    check(u == 0 ? "hold_u0" : "hold_u1", hold[u], 1);
                    if (expq[u].size() == 0) note_fail(u == 0 ? "extra_write_u0" : "extra_write_u1");
                    else check(u == 0 ? "write_u0" : "write_u1", {b_addr[u], b_piece[u]}, expq[u].pop_front());
                    if (u == 1) hist[b_piece[1]]++;
                end
                if (done[u]) begin
                    dcnt[u]++;
                    check(u == 0 ? "write_count_u0" : "write_count_u1", wcnt[u], 32);
                    check(u == 0 ? "done_we_u0" : "done_we_u1", b_we[u], 0);
                    wcnt[u] = 0;
                    if (expdone[u].size() == 0) note_fail(u == 0 ? "extra_done_u0" : "extra_done_u1");
                    else check(u == 0 ? "done_cycle_u0" : "done_cycle_u1", cyc, expdone[u].pop_front());
                    if (u == 1) begin
                        int nbad;
                        int ex;
                        nbad = 0;
                        for (int v = 0; v < 32; v++) begin
                            if (v[0])                 ex = 0;
                            else if (v[3:1] == 3'd7)  ex = 1;
                            else if (v[3:1] == 3'd1)  ex = 5;
                            else if (v[3:1] == 3'd0)  ex = 0;
                            else                      ex = 2;
                            if (hist[v] != ex) nbad++;
                            hist[v] = 0;
                        end
                        check("piece_set_u1", nbad, 0);
                    end
                end
            end
        end
    end

    task automatic do_start(input logic p0, input logic p1);
        @(negedge CLK);
        start = 1'b1;
        if (p0) push_setup(0, adv(adv(m_lfsr)));
        if (p1) push_setup(1, adv(adv(m_lfsr)));
        #1;
        if (p1) begin
            check("start_cycle_we", b_we[1], gl_we);
            check("start_cycle_addr", b_addr[1], gl_addr);
        end
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy != 2'b00 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (busy != 2'b00) note_fail("idle_timeout");
    endtask

    int d0, d1, n;

    initial begin
        for (int u = 0; u < 2; u++) begin wcnt[u] = 0; dcnt[u] = 0; end
        for (int v = 0; v < 32; v++) hist[v] = 0;
        RESET = 1'b1; start = 1'b0; gl_we = 1'b0; gl_addr = 5'd0; gl_piece = 5'd0;
        @(negedge CLK);
        gl_we = 1'b1; gl_addr = 5'd3; gl_piece = 5'd9;
        #1;
        check("reset_busy", busy, 2'b00);
        check("reset_done", done, 2'b00);
        check("reset_hold", hold, 2'b00);
        check("reset_we_follows", b_we[1], 1);
        check("reset_addr_follows", b_addr[1], 5'd3);
        @(negedge CLK);
        RESET = 1'b0;

        // Idle passthrough
        gl_we = 1'b1; gl_addr = 5'b01_011; gl_piece = 5'b1_100_1;
        #1;
        for (int u = 0; u < 2; u++) begin
            check("pass_addr", b_addr[u], 5'b01_011);
            check("pass_piece", b_piece[u], 5'b1_100_1);
            check("pass_we", b_we[u], 1);
            check("pass_busy", busy[u], 0);
            check("pass_done", done[u], 0);
        end
        @(negedge CLK);
        gl_we = 1'b0;
        #1;
        check("pass_we_low", b_we[1], 0);
        repeat (7) @(negedge CLK);

        // Setup 1: default seed, start 10 cycles after reset
        d0 = dcnt[0]; d1 = dcnt[1];
        do_start(1'b1, 1'b1);
        wait_idle();
        check("setup1_dones_u0", dcnt[0] - d0, 1);
        check("setup1_dones_u1", dcnt[1] - d1, 1);

        // Setup 2: game logic hammers writes throughout; starts in the same cycle as a write
        gl_we = 1'b1; gl_addr = 5'd7; gl_piece = 5'd31;
        d1 = dcnt[1];
        do_start(1'b1, 1'b1);
        n = 0;
        while (!done[1] && n < 1000) begin @(negedge CLK); n++; end
        if (!done[1]) note_fail("lockout_done_timeout");
        @(negedge CLK);
        #1;
        check("resume_busy", busy[1], 0);
        check("resume_we", b_we[1], 1);
        check("resume_addr", b_addr[1], 5'd7);
        check("resume_piece", b_piece[1], 5'd31);
        wait_idle();
        check("lockout_dones_u1", dcnt[1] - d1, 1);
        gl_we = 1'b0;

        // Setup 3: second start mid-SHUFFLE is ignored
        d0 = dcnt[0]; d1 = dcnt[1];
        do_start(1'b1, 1'b1);
        repeat (10) @(negedge CLK);
        do_start(1'b0, 1'b0);
        wait_idle();
        check("restart_dones_u0", dcnt[0] - d0, 1);
        check("restart_dones_u1", dcnt[1] - d1, 1);

        // Setup 4: reset lands while unit 1 writes square 12
        gl_we = 1'b1; gl_addr = 5'd2; gl_piece = 5'd4;
        do_start(1'b1, 1'b1);
        n = 0;
        while (!(busy[1] && b_we[1] && b_addr[1] == 5'd12) && n < 1000) begin @(negedge CLK); n++; end
        if (!(busy[1] && b_addr[1] == 5'd12)) note_fail("k12_timeout");
        RESET = 1'b1;
        #1;
        check("midreset_busy", busy, 2'b00);
        check("midreset_we", b_we[1], 1);
        check("midreset_addr", b_addr[1], 5'd2);
        check("midreset_piece", b_piece[1], 5'd4);
        flush();
        @(negedge CLK);
        RESET = 1'b0; gl_we = 1'b0;
        repeat (3) @(negedge CLK);
        d0 = dcnt[0]; d1 = dcnt[1];
        do_start(1'b1, 1'b1);
        wait_idle();
        check("after_reset_dones_u0", dcnt[0] - d0, 1);
        check("after_reset_dones_u1", dcnt[1] - d1, 1);
        check("left_expected_u1", expq[1].size(), 0);

        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
